// File: rtl/redirect_pkg.sv
// Shared types and constants for the front-end redirect unit.
// program_counter_t is the machine program-counter type used across the core.
package redirect_pkg;

    localparam int unsigned PC_W = 32;

    typedef logic [PC_W-1:0] program_counter_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        COMMIT = 2'd3
    } redirect_rank_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_WINDOW = 1'b1
    } redirect_state_t;

    // Flush masks are {commit, exec, fetch/decode}.
    localparam logic [2:0] FLUSH_NONE   = 3'b000;
    localparam logic [2:0] FLUSH_DECODE = 3'b001;
    localparam logic [2:0] FLUSH_EXEC   = 3'b011;
    localparam logic [2:0] FLUSH_COMMIT = 3'b111;

    function automatic logic [2:0] flush_mask(input redirect_rank_t rank);
        case (rank)
            DECODE:  return FLUSH_DECODE;
            EXEC:    return FLUSH_EXEC;
            COMMIT:  return FLUSH_COMMIT;
            default: return FLUSH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/redirect_unit_if.sv
// Redirect request/response bundle: stage requests in, program-counter alter out.
interface redirect_unit_if;
    import redirect_pkg::*;

    logic             commit_redirect;
    program_counter_t commit_pc;
    logic             exec_redirect;
    program_counter_t exec_pc;
    logic             decode_redirect;
    program_counter_t decode_pc;
    logic             alter;
    program_counter_t pc;
    logic [2:0]       flush;

    modport master (
        output commit_redirect, commit_pc, exec_redirect, exec_pc,
               decode_redirect, decode_pc,
        input  alter, pc, flush
    );

    modport slave (
        input  commit_redirect, commit_pc, exec_redirect, exec_pc,
               decode_redirect, decode_pc,
        output alter, pc, flush
    );

endinterface

// File: rtl/redirect_unit.sv
// Arbitrates commit/exec/decode redirects with a post-redirect squash window.
// Decode-sourced redirects participate only when REDIRECT_DECODE_SRC_EN is defined.
module redirect_unit
    import redirect_pkg::*;
#(
    parameter int unsigned SQUASH_CYCLES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_commit_redirect,
    input  program_counter_t i_commit_pc,
    input  logic             i_exec_redirect,
    input  program_counter_t i_exec_pc,
    input  logic             i_decode_redirect,
    input  program_counter_t i_decode_pc,
    output logic             o_alter,
    output program_counter_t o_pc,
    output logic [2:0]       o_flush
);

    localparam int unsigned      CNT_W    = $clog2(SQUASH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SQUASH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    redirect_state_t  r_state, w_state_d;
    redirect_rank_t   r_win_rank, w_win_rank_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;

    logic             r_alter, w_alter_d;
    program_counter_t r_pc, w_pc_d;
    logic [2:0]       r_flush, w_flush_d;

    redirect_rank_t   w_cand_rank;
    program_counter_t w_cand_pc;
    logic             w_accept;
    logic             w_dec_req;

`ifdef REDIRECT_DECODE_SRC_EN
    assign w_dec_req = i_decode_redirect;
`else
    logic w_unused_decode;
    assign w_unused_decode = ^{i_decode_redirect, i_decode_pc};
    assign w_dec_req       = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_cand_rank = NONE;
        w_cand_pc   = '0;
        if (i_commit_redirect) begin
            w_cand_rank = COMMIT;
            w_cand_pc   = i_commit_pc;
        end else if (i_exec_redirect) begin
            w_cand_rank = EXEC;
            w_cand_pc   = i_exec_pc;
        end else if (w_dec_req) begin
            w_cand_rank = DECODE;
            w_cand_pc   = i_decode_pc;
        end
    end

    // IDLE holds rank NONE, so one strict compare covers both "no window" and
    // "outranks the window"; equal-rank requests inside a window are wrong-path.
    assign w_accept = (w_cand_rank != NONE) && (w_cand_rank > r_win_rank);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_win_rank <= NONE;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_win_rank <= w_win_rank_d;
            r_cnt      <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_win_rank_d = r_win_rank;
        w_cnt_d      = r_cnt;
        if (w_accept) begin
            w_state_d    = ST_WINDOW;
            w_win_rank_d = w_cand_rank;
            w_cnt_d      = CNT_LOAD;
        end else if (r_state == ST_WINDOW) begin
            if (r_cnt <= CNT_ONE) begin
                w_state_d    = ST_IDLE;
                w_win_rank_d = NONE;
                w_cnt_d      = '0;
            end else begin
                w_cnt_d = r_cnt - CNT_ONE;
            end
        end
    end

    always_comb begin
        w_alter_d = w_accept;
        w_pc_d    = r_pc;
        w_flush_d = FLUSH_NONE;
        if (w_accept) begin
            w_pc_d    = w_cand_pc;
            w_flush_d = flush_mask(w_cand_rank);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alter <= 1'b0;
            r_pc    <= '0;
            r_flush <= FLUSH_NONE;
        end else begin
            r_alter <= w_alter_d;
            r_pc    <= w_pc_d;
            r_flush <= w_flush_d;
        end
    end

    assign o_alter = r_alter;
    assign o_pc    = r_pc;
    assign o_flush = r_flush;

endmodule

// File: tb/tb_redirect_unit.sv
// Self-checking bench for redirect_unit: timestamp-based window model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_redirect_unit;
    import redirect_pkg::*;

    localparam int unsigned SQ = 3;
`ifdef REDIRECT_DECODE_SRC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    redirect_unit_if rif();

    redirect_unit #(.SQUASH_CYCLES(SQ)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_commit_redirect (rif.commit_redirect),
        .i_commit_pc       (rif.commit_pc),
        .i_exec_redirect   (rif.exec_redirect),
        .i_exec_pc         (rif.exec_pc),
        .i_decode_redirect (rif.decode_redirect),
        .i_decode_pc       (rif.decode_pc),
        .o_alter           (rif.alter),
        .o_pc              (rif.pc),
        .o_flush           (rif.flush)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a window opened by an accept at edge e covers edges
    // e+1 .. e+SQ; a request is taken if no window covers its edge or it outranks it.
    logic [2:0]  flush_tbl [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
    bit          m_valid = 1'b0;
    int          cyc = 0;
    int          win_end = -1;
    int          win_rank = 0;
    logic        m_alter;
    logic [31:0] m_pc;
    logic [2:0]  m_flush;

    initial begin
        int          cand;
        logic [31:0] cpc;
        bit          open;
        forever begin
            @(posedge i_clk);
            if (i_rst) begin
                m_valid  = 1'b1;
                m_alter  = 1'b0;
                m_pc     = '0;
                m_flush  = '0;
                win_rank = 0;
                win_end  = -1;
            end else if (m_valid) begin
                cand = 0;
                cpc  = '0;
                if (DEC_EN && rif.decode_redirect) begin cand = 1; cpc = rif.decode_pc; end
                if (rif.exec_redirect)             begin cand = 2; cpc = rif.exec_pc;   end
                if (rif.commit_redirect)           begin cand = 3; cpc = rif.commit_pc; end
                open = (cyc <= win_end);
                if (cand != 0 && (!open || cand > win_rank)) begin
                    m_alter  = 1'b1;
                    m_pc     = cpc;
                    m_flush  = flush_tbl[cand];
                    win_rank = cand;
                    win_end  = cyc + SQ;
                end else begin
                    m_alter = 1'b0;
                    m_flush = '0;
                end
            end
            cyc++;
            #1;
            if (m_valid) begin
                check("model_alter", {31'd0, rif.alter}, {31'd0, m_alter});
                check("model_pc",    rif.pc,             m_pc);
                check("model_flush", {29'd0, rif.flush}, {29'd0, m_flush});
            end
        end
    end

    task automatic apply(input bit rst,
                         input bit c, input logic [31:0] cpc,
                         input bit e, input logic [31:0] epc,
                         input bit d, input logic [31:0] dpc);
        @(negedge i_clk);
        i_rst               = rst;
        rif.commit_redirect = c;
        rif.commit_pc       = cpc;
        rif.exec_redirect   = e;
        rif.exec_pc         = epc;
        rif.decode_redirect = d;
        rif.decode_pc       = dpc;
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic expect_out(input string name, input logic alter,
                              input logic [31:0] pc, input logic [2:0] flush);
        check({name, "_alter"}, {31'd0, rif.alter}, {31'd0, alter});
        check({name, "_pc"},    rif.pc,             pc);
        check({name, "_flush"}, {29'd0, rif.flush}, {29'd0, flush});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rif.commit_redirect = 1'b0;
        rif.commit_pc       = '0;
        rif.exec_redirect   = 1'b0;
        rif.exec_pc         = '0;
        rif.decode_redirect = 1'b0;
        rif.decode_pc       = '0;

        apply(1'b1, 1'b1, 32'hdead, 1'b1, 32'hbeef, 1'b1, 32'hcafe);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("reset", 1'b0, 32'h0, 3'b000);
        idle(3);

        // Single exec redirect from idle, then one-cycle strobe with held pc.
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 32'h0);
        expect_out("exec_hit", 1'b1, 32'h1000, 3'b011);
        idle(1);
        expect_out("exec_after", 1'b0, 32'h1000, 3'b000);
        idle(4);

        // All three at once: commit wins.
        apply(1'b0, 1'b1, 32'h2000, 1'b1, 32'h3000, 1'b1, 32'h4000);
        expect_out("prio", 1'b1, 32'h2000, 3'b111);
        idle(1);
        expect_out("prio_after", 1'b0, 32'h2000, 3'b000);
        idle(4);

        // Equal rank inside window dropped; after window closes accepted.
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 32'h0);
        expect_out("win_open", 1'b1, 32'h1000, 3'b011);
        idle(1);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h5000, 1'b0, 32'h0);
        expect_out("win_drop", 1'b0, 32'h1000, 3'b000);
        idle(1);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h6000, 1'b0, 32'h0);
        expect_out("win_reopen", 1'b1, 32'h6000, 3'b011);
        idle(4);

        // Higher rank preempts and restarts window at commit rank.
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 32'h0);
        expect_out("pre_exec", 1'b1, 32'h1000, 3'b011);
        apply(1'b0, 1'b1, 32'h8000, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("pre_commit", 1'b1, 32'h8000, 3'b111);
        idle(1);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h9000);
        expect_out("pre_dec_drop", 1'b0, 32'h8000, 3'b000);
        idle(5);

        // Reset mid-window discards requests and clears the window.
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 32'h0);
        expect_out("rst_pre", 1'b1, 32'h1000, 3'b011);
        apply(1'b1, 1'b1, 32'h2222, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("rst_mid", 1'b0, 32'h0, 3'b000);
        idle(1);
        expect_out("rst_after", 1'b0, 32'h0, 3'b000);
        apply(1'b0, 1'b0, 32'h0, !DEC_EN, 32'h7000, DEC_EN, 32'h7000);
        expect_out("rst_clear", 1'b1, 32'h7000, DEC_EN ? 3'b001 : 3'b011);
        idle(4);

`ifdef REDIRECT_DECODE_SRC_EN
        apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4000);
        expect_out("dec_only", 1'b1, 32'h4000, 3'b001);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4100);
        expect_out("dec_again", 1'b0, 32'h4000, 3'b000);
`else
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4000);
            expect_out("dec_ignored", 1'b0, 32'h7000, 3'b000);
        end
`endif
        idle(4);

        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 63) == 0,
                  $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 3) == 0, $urandom,
                  $urandom_range(0, 2) == 0, $urandom);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/redirect_unit.md
REDIRECT_UNIT -- requirements
Module: redirect_unit

Interface
REQ-001 SHALL have parameter SQUASH_CYCLES, default 3, meaning cycles a squash window stays open after an accepted redirect (range 1..15).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on posedge.
REQ-003 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_commit_redirect, input, 1, trap/exception redirect request from commit (rank 3).
REQ-005 SHALL have port i_commit_pc, input, program_counter_t, commit redirect target.
REQ-006 SHALL have port i_exec_redirect, input, 1, branch-mispredict redirect request from execute (rank 2).
REQ-007 SHALL have port i_exec_pc, input, program_counter_t, execute redirect target.
REQ-008 SHALL have port i_decode_redirect, input, 1, predicted-jump redirect request from decode (rank 1).
REQ-009 SHALL have port i_decode_pc, input, program_counter_t, decode redirect target.
REQ-010 SHALL have port o_alter, output, 1, one-cycle redirect strobe driving the program counter's alter input.
REQ-011 SHALL have port o_pc, output, program_counter_t, redirect target, valid when o_alter=1.
REQ-012 SHALL have port o_flush, output, 3, stage flush mask {commit, exec, fetch/decode}, valid with o_alter.

Function
REQ-013 SHALL select per cycle the highest-ranked asserted request (commit > exec > decode) as candidate.
REQ-014 SHALL accept the candidate when no squash window is open, or when candidate rank > window rank.
REQ-015 SHALL drop (never queue) non-accepted and lower-ranked simultaneous requests.
REQ-016 SHALL register outputs: request accepted in cycle N -> o_alter=1 and o_pc=target in cycle N+1 only, latency exactly 1.
REQ-017 SHALL drive o_flush in cycle N+1 as: decode 3'b001, exec 3'b011, commit 3'b111; 3'b000 when o_alter=0.
REQ-018 SHALL hold o_pc at its last value when o_alter=0.
REQ-019 SHALL keep state IDLE (window rank 0) or WINDOW (rank 1..3, countdown counter).
REQ-020 SHALL on acceptance enter WINDOW with rank = accepted rank, counter = SQUASH_CYCLES, regardless of prior state.
REQ-021 SHALL in WINDOW without acceptance decrement counter each cycle; at counter 1 -> IDLE next cycle, rank 0.
REQ-022 SHALL treat equal-rank requests during an open window as wrong-path and drop them.
REQ-023 SHALL size counter to $clog2(SQUASH_CYCLES+1) bits, no wrap: counter never below 0.

Reset
REQ-024 SHALL on i_rst=1 at a clock edge set o_alter=0, o_flush=0, o_pc=0, state IDLE, counter=0, rank=0.
REQ-025 SHALL ignore all requests in any cycle where i_rst=1, including mid-window; no redirect issues from pre-reset requests.

Configuration
REQ-026 SHALL honour macro REDIRECT_DECODE_SRC_EN: when defined, decode requests participate per REQ-013..022.
REQ-027 SHALL when REDIRECT_DECODE_SRC_EN is undefined keep i_decode_redirect/i_decode_pc ports but ignore them entirely; only ranks 2,3 exist.

Structure
REQ-028 SHALL place redirect_rank_t (2-bit enum NONE/DECODE/EXEC/COMMIT) and flush-mask constants in shared package redirect_pkg; program_counter_t comes from the existing pc include.
REQ-029 SHALL be a single module with no sub-modules; squash counter inline.

Verification
REQ-030 SHALL cover: exec redirect 0x1000 in cycle 5, idle before -> cycle 6 o_alter=1, o_pc=0x1000, o_flush=3'b011; cycle 7 o_alter=0.
REQ-031 SHALL cover: commit 0x2000 and exec 0x3000 and decode 0x4000 same cycle -> single redirect o_pc=0x2000, o_flush=3'b111.
REQ-032 SHALL cover: SQUASH_CYCLES=3, exec 0x1000 cycle 5, exec 0x5000 cycle 7 -> dropped; exec 0x6000 cycle 9 -> accepted, o_pc=0x6000 cycle 10.
REQ-033 SHALL cover: exec 0x1000 cycle 5, commit 0x8000 cycle 6 -> o_pc=0x8000 cycle 7, window restarts at rank 3; decode 0x9000 cycle 8 dropped.
REQ-034 SHALL cover: exec 0x1000 cycle 5, i_rst=1 cycle 6 -> cycle 7 o_alter=0; decode 0x7000 cycle 8 accepted (window cleared), o_pc=0x7000 cycle 9.
REQ-035 SHALL cover: REDIRECT_DECODE_SRC_EN undefined, decode 0x4000 alone -> o_alter stays 0 for 5 cycles.
